// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch PC sequencer: redirect op codes,
// FSM state encoding and the default reset and exception addresses.
package pc_sequencer_pkg;

  // Redirect request kinds issued by the D stage
  typedef enum logic [1:0] {
    REDIR_BR  = 2'b00,  // conditional branch, PC-relative
    REDIR_J   = 2'b01,  // j / jal, region-absolute
    REDIR_JR  = 2'b10,  // jr / jalr, register target
    REDIR_RSV = 2'b11   // reserved, never redirects
  } redir_op_e;

  // Sequencer states; pend and flush are decoded directly from these
  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,   // normal fetch, no buffered redirect
    ST_HOLD  = 2'b01,   // redirect buffered while stalled
    ST_FLUSH = 2'b10    // one cycle after exception entry or eret
  } seq_state_e;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC  = 32'h0000_4180;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect target computation. All arithmetic wraps
// modulo 2^32, and the low two bits are passed through untouched so a
// misaligned target reaches fetch and faults there.
module pc_target_calc (
  input  logic [1:0]  redir_op,
  input  logic [31:0] redir_pc,
  input  logic [25:0] imm26,
  input  logic [31:0] ra,
  output logic [31:0] target,
  output logic        target_vld
);
  import pc_sequencer_pkg::*;

  // Select the target for the requested transfer kind
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    target     = '0;
    target_vld = 1'b0;
    case (redir_op)
      REDIR_BR: begin
        target     = redir_pc + 32'd4 + {{14{imm26[15]}}, imm26[15:0], 2'b00};
        target_vld = 1'b1;
      end
      REDIR_J: begin
        target     = {redir_pc[31:28], imm26, 2'b00};
        target_vld = 1'b1;
      end
      REDIR_JR: begin
        target     = ra;
        target_vld = 1'b1;
      end
      default: begin
        target     = '0;
        target_vld = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC owner. Applies exception entry, eret return, stall hold,
// buffered and direct redirects, and sequential fetch in strict priority.
// pc, epc and the state register are the only state; pend and flush are
// decoded from the state flop, so no input reaches them combinationally.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = pc_sequencer_pkg::RESET_PC,
  parameter logic [31:0] EXC_VEC  = pc_sequencer_pkg::EXC_VEC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redir_vld,
  input  logic [1:0]  redir_op,
  input  logic [31:0] redir_pc,
  input  logic [25:0] imm26,
  input  logic [31:0] ra,
  input  logic        exc_req,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic        eret_req,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        flush,
  output logic [31:0] epc,
  output logic        pend
);
  import pc_sequencer_pkg::*;

  seq_state_e  state;
  logic [31:0] pend_pc;
  logic [31:0] target;
  logic        target_vld;

  pc_target_calc u_target (
    .redir_op   (redir_op),
    .redir_pc   (redir_pc),
    .imm26      (imm26),
    .ra         (ra),
    .target     (target),
    .target_vld (target_vld)
  );

  assign pc4   = pc + 32'd4;
  assign pend  = (state == ST_HOLD);
  assign flush = (state == ST_FLUSH);

  // Sequencer FSM and PC/EPC/buffer registers with the full update priority
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and evaluation order does not matter.
    if (!reset) begin
      state   <= ST_RUN;
      pc      <= RESET_PC;
      epc     <= '0;
      pend_pc <= '0;
    end else if (exc_req) begin
      pc    <= EXC_VEC;
      epc   <= exc_bd ? (exc_pc - 32'd4) : exc_pc;
      state <= ST_FLUSH;
    end else if (eret_req) begin
      pc    <= epc;
      state <= ST_FLUSH;
    end else if (stall) begin
      // pc holds; only the first redirect seen during a stall is kept
      if (redir_vld && target_vld && !pend) begin
        pend_pc <= target;
        state   <= ST_HOLD;
      end else if (!pend) begin
        state <= ST_RUN;
      end
    end else if (pend) begin
      // Buffered redirect wins over anything arriving this cycle
      pc    <= pend_pc;
      state <= ST_RUN;
    end else if (redir_vld && target_vld) begin
      pc    <= target;
      state <= ST_RUN;
    end else begin
      pc    <= pc + 32'd4;
      state <= ST_RUN;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expected values.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redir_vld;
  logic [1:0]  redir_op;
  logic [31:0] redir_pc;
  logic [25:0] imm26;
  logic [31:0] ra;
  logic        exc_req;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic        eret_req;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        flush;
  logic [31:0] epc;
  logic        pend;

  int n_total = 0;
  int n_bad   = 0;

  pc_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .redir_vld (redir_vld),
    .redir_op  (redir_op),
    .redir_pc  (redir_pc),
    .imm26     (imm26),
    .ra        (ra),
    .exc_req   (exc_req),
    .exc_pc    (exc_pc),
    .exc_bd    (exc_bd),
    .eret_req  (eret_req),
    .pc        (pc),
    .pc4       (pc4),
    .flush     (flush),
    .epc       (epc),
    .pend      (pend)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance one edge and settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall     = 1'b0;
    redir_vld = 1'b0;
    redir_op  = 2'b00;
    redir_pc  = '0;
    imm26     = '0;
    ra        = '0;
    exc_req   = 1'b0;
    exc_pc    = '0;
    exc_bd    = 1'b0;
    eret_req  = 1'b0;
  endtask

  task automatic jr(input logic [31:0] tgt);
    redir_vld = 1'b1;
    redir_op  = 2'b10;
    ra        = tgt;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    repeat (3) step();
    check("rst_pc", pc, 32'h0000_3000);
    check("rst_epc", epc, 32'h0);
    check("rst_flush", {31'b0, flush}, 32'h0);
    check("rst_pend", {31'b0, pend}, 32'h0);
    reset = 1'b1;
    step();
    check("seq_1", pc, 32'h0000_3004);
    step();
    check("seq_2", pc, 32'h0000_3008);

    // Backward branch: 0x3004 + 4 - 8
    redir_vld = 1'b1; redir_op = 2'b00; redir_pc = 32'h0000_3004; imm26 = 26'h000FFFE;
    step();
    check("branch", pc, 32'h0000_3000);
    // j into same region
    redir_op = 2'b01; imm26 = 26'h0000C03;
    step();
    check("jump", pc, 32'h0000_300C);
    idle_inputs();
    step();
    check("after_j", pc, 32'h0000_3010);
    check("pc4", pc4, 32'h0000_3014);

    // Redirect during stall is buffered; a second one is dropped
    stall = 1'b1; jr(32'h0000_3100);
    step();
    check("stall_hold", pc, 32'h0000_3010);
    check("stall_pend", {31'b0, pend}, 32'h1);
    jr(32'h0000_3200);
    step();
    check("stall_drop", pc, 32'h0000_3010);
    idle_inputs();
    step();
    check("unbuf_pc", pc, 32'h0000_3100);
    check("unbuf_pend", {31'b0, pend}, 32'h0);
    step();
    check("unbuf_seq", pc, 32'h0000_3104);

    // Redirect concurrent with buffer release is dropped
    stall = 1'b1; jr(32'h0000_3300);
    step();
    stall = 1'b0; jr(32'h0000_3400);
    step();
    check("release_wins", pc, 32'h0000_3300);

    // Reserved op is ignored
    redir_vld = 1'b1; redir_op = 2'b11; ra = 32'h0000_5000;
    step();
    check("op_rsv", pc, 32'h0000_3304);

    // Exception beats stall, eret and a buffered redirect
    idle_inputs();
    stall = 1'b1; jr(32'h0000_3500);
    step();
    check("pre_exc_pend", {31'b0, pend}, 32'h1);
    exc_req = 1'b1; exc_pc = 32'h0000_3010; exc_bd = 1'b1; eret_req = 1'b1;
    step();
    check("exc_pc", pc, 32'h0000_4180);
    check("exc_epc", epc, 32'h0000_300C);
    check("exc_flush", {31'b0, flush}, 32'h1);
    check("exc_pend", {31'b0, pend}, 32'h0);
    idle_inputs();
    stall = 1'b1;
    step();
    check("flush_stall_pc", pc, 32'h0000_4180);
    check("flush_low", {31'b0, flush}, 32'h0);
    stall = 1'b0;
    step();
    check("handler_seq", pc, 32'h0000_4184);

    // Eret with a buffered redirect pending
    stall = 1'b1; jr(32'h0000_3600);
    step();
    redir_vld = 1'b0; eret_req = 1'b1;
    step();
    check("eret_pc", pc, 32'h0000_300C);
    check("eret_flush", {31'b0, flush}, 32'h1);
    check("eret_pend", {31'b0, pend}, 32'h0);
    idle_inputs();
    step();
    check("eret_seq", pc, 32'h0000_3010);
    check("eret_flush_off", {31'b0, flush}, 32'h0);

    // Exception outside a delay slot saves exc_pc itself
    exc_req = 1'b1; exc_pc = 32'h0000_3020; exc_bd = 1'b0;
    step();
    check("exc_nobd_epc", epc, 32'h0000_3020);
    idle_inputs();

    // Wrap and misaligned targets
    jr(32'hFFFF_FFFC);
    step();
    check("wrap_pre", pc, 32'hFFFF_FFFC);
    check("wrap_pc4", pc4, 32'h0);
    idle_inputs();
    step();
    check("wrap_pc", pc, 32'h0);
    jr(32'h0000_3102);
    step();
    check("misalign", pc, 32'h0000_3102);

    // Reset while a redirect is buffered dominates everything
    stall = 1'b1; jr(32'h0000_3700);
    step();
    check("pre_rst_pend", {31'b0, pend}, 32'h1);
    reset = 1'b0; exc_req = 1'b1; exc_pc = 32'h0000_3040;
    step();
    check("mid_rst_pc", pc, 32'h0000_3000);
    check("mid_rst_pend", {31'b0, pend}, 32'h0);
    check("mid_rst_epc", epc, 32'h0);
    check("mid_rst_flush", {31'b0, flush}, 32'h0);
    idle_inputs();
    reset = 1'b1;
    step();
    check("post_rst_seq", pc, 32'h0000_3004);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
